// File: rtl/enigma_core.sv
// enigma_core: two-stage pipelined three-rotor Enigma (rotors I/II/III, reflector UKW-B,
// ring settings A). The optional plugboard is enabled by defining ENIGMA_PLUGBOARD_EN.
module enigma_core #(
   parameter int unsigned SYM_W   = 7,
   parameter logic [14:0] POS_RST = 15'd0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [SYM_W-1:0] sym_i,
   input  logic             cfg_ld_i,
   input  logic [14:0]      cfg_pos_i,
`ifdef ENIGMA_PLUGBOARD_EN
   input  logic             plug_wr_i,
   input  logic [4:0]       plug_a_i,
   input  logic [4:0]       plug_b_i,
   input  logic             plug_clr_i,
`endif
   output logic [SYM_W-1:0] sym_o,
   output logic [14:0]      pos_o
);

   localparam int unsigned NSYM = 26;

   localparam logic [4:0] W_I [NSYM] = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21,
      5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1,
      5'd17, 5'd2, 5'd9};
   localparam logic [4:0] W_II [NSYM] = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23,
      5'd1, 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5,
      5'd21, 5'd14, 5'd4};
   localparam logic [4:0] W_III [NSYM] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17,
      5'd19, 5'd23, 5'd13, 5'd24, 5'd4, 5'd16, 5'd6, 5'd21, 5'd8, 5'd20, 5'd0, 5'd25, 5'd12, 5'd22,
      5'd18, 5'd10, 5'd14};
   localparam logic [4:0] W_UKW [NSYM] = '{5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15,
      5'd23, 5'd13, 5'd6, 5'd14, 5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21,
      5'd9, 5'd0, 5'd19};

   function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 6'd26) s = s - 6'd26;
      return s[4:0];
   endfunction

   function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} - {1'b0, b};
      if (a < b) s = s + 6'd26;
      return s[4:0];
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] a);
      return (a == 5'd25) ? 5'd0 : a + 5'd1;
   endfunction

   function automatic logic [4:0] mod26(input logic [4:0] a);
      return (a > 5'd25) ? a - 5'd26 : a;
   endfunction

   // sel: 0 = rotor I, 1 = rotor II, 2 = rotor III, 3 = reflector
   function automatic logic [4:0] wire_at(input logic [1:0] sel, input logic [4:0] i);
      case (sel)
         2'd0:    return W_I[i];
         2'd1:    return W_II[i];
         2'd2:    return W_III[i];
         default: return W_UKW[i];
      endcase
   endfunction

   // One rotor pass at offset p; the inverse pass searches the same table backwards.
   function automatic logic [4:0] rotor(input logic [1:0] sel, input logic inv,
                                        input logic [4:0] c, input logic [4:0] p);
      logic [4:0] idx;
      logic [4:0] w;
      logic [4:0] e;
      idx = add26(c, p);
      w   = idx;
      for (int i = 0; i < int'(NSYM); i++) begin
         e = wire_at(sel, 5'(i));
         if (!inv && (5'(i) == idx)) w = e;
         if (inv && (e == idx))      w = 5'(i);
      end
      return sub26(w, p);
   endfunction

   logic             sym_vld;
   logic             take;
   logic [4:0]       c_raw;
   logic [4:0]       c_in;
   logic [14:0]      pos_step;
   logic             s1_vld;
   logic [4:0]       s1_c;
   logic [14:0]      s1_pos;
   logic [4:0]       ret;
   logic [4:0]       c_out;

   // Input qualification and rotor stepping (right always, middle double-steps at E)
   always_comb begin
      sym_vld = ($signed(sym_i) > $signed(SYM_W'(0))) && ($signed(sym_i) < $signed(SYM_W'(27)));
      take    = sym_vld && !cfg_ld_i;
      c_raw   = take ? 5'(sym_i - SYM_W'(1)) : 5'd0;
      pos_step[4:0]   = inc26(pos_o[4:0]);
      pos_step[9:5]   = ((pos_o[4:0] == 5'd21) || (pos_o[9:5] == 5'd4)) ? inc26(pos_o[9:5])
                                                                         : pos_o[9:5];
      pos_step[14:10] = (pos_o[9:5] == 5'd4) ? inc26(pos_o[14:10]) : pos_o[14:10];
   end

   // Rotor chain from stage-1 registers: R, M, L, reflector, L^-1, M^-1, R^-1
   always_comb begin
      ret = rotor(2'd2, 1'b0, s1_c, s1_pos[4:0]);
      ret = rotor(2'd1, 1'b0, ret,  s1_pos[9:5]);
      ret = rotor(2'd0, 1'b0, ret,  s1_pos[14:10]);
      ret = wire_at(2'd3, ret);
      ret = rotor(2'd0, 1'b1, ret,  s1_pos[14:10]);
      ret = rotor(2'd1, 1'b1, ret,  s1_pos[9:5]);
      ret = rotor(2'd2, 1'b1, ret,  s1_pos[4:0]);
   end

`ifdef ENIGMA_PLUGBOARD_EN
   logic [4:0] plug_map [NSYM];
   logic       plug_ok;
   logic [4:0] plug_pa;
   logic [4:0] plug_pb;

   // Legal swap request and the current partners of both letters
   always_comb begin
      plug_ok = plug_wr_i && (plug_a_i != plug_b_i) && (plug_a_i < 5'd26) && (plug_b_i < 5'd26);
      plug_pa = plug_ok ? plug_map[plug_a_i] : 5'd0;
      plug_pb = plug_ok ? plug_map[plug_b_i] : 5'd0;
   end

   // Plugboard map: clear wins over write; old partners are released before pairing a<->b
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NSYM); i++) plug_map[i] <= 5'(i);
      end else if (plug_clr_i) begin
         for (int i = 0; i < int'(NSYM); i++) plug_map[i] <= 5'(i);
      end else if (plug_ok) begin
         for (int i = 0; i < int'(NSYM); i++) begin
            if (5'(i) == plug_a_i)      plug_map[i] <= plug_b_i;
            else if (5'(i) == plug_b_i) plug_map[i] <= plug_a_i;
            else if ((5'(i) == plug_pa) || (5'(i) == plug_pb)) plug_map[i] <= 5'(i);
         end
      end
   end

   assign c_in  = plug_map[c_raw];
   assign c_out = plug_map[ret];
`else
   assign c_in  = c_raw;
   assign c_out = ret;
`endif

   // Position register and stage 1: load beats a same-cycle symbol
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pos_o  <= POS_RST;
         s1_vld <= 1'b0;
         s1_c   <= 5'd0;
         s1_pos <= POS_RST;
      end else begin
         s1_vld <= take;
         s1_c   <= c_in;
         s1_pos <= pos_step;
         if (cfg_ld_i) begin
            pos_o <= {mod26(cfg_pos_i[14:10]), mod26(cfg_pos_i[9:5]), mod26(cfg_pos_i[4:0])};
         end else if (take) begin
            pos_o <= pos_step;
         end
      end
   end

   // Stage 2: ciphertext code 1..26, or 0 when the slot is empty
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sym_o <= '0;
      else       sym_o <= s1_vld ? SYM_W'(c_out) + SYM_W'(1) : '0;
   end

endmodule

// File: tb/tb_enigma_core.sv
// tb_enigma_core: randomized scoreboard bench for enigma_core against a letter-level Enigma model.
// Plugboard checks are included when ENIGMA_PLUGBOARD_EN is defined.
module tb_enigma_core;

   localparam int unsigned SYM_W   = 7;
   localparam logic [14:0] POS_RST = 15'd0;

   logic             clk_i;
   logic             rst_i;
   logic [SYM_W-1:0] sym_i;
   logic             cfg_ld_i;
   logic [14:0]      cfg_pos_i;
   logic [SYM_W-1:0] sym_o;
   logic [14:0]      pos_o;
`ifdef ENIGMA_PLUGBOARD_EN
   logic             plug_wr_i;
   logic [4:0]       plug_a_i;
   logic [4:0]       plug_b_i;
   logic             plug_clr_i;
`endif

   enigma_core #(.SYM_W(SYM_W), .POS_RST(POS_RST)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .sym_i     (sym_i),
      .cfg_ld_i  (cfg_ld_i),
      .cfg_pos_i (cfg_pos_i),
`ifdef ENIGMA_PLUGBOARD_EN
      .plug_wr_i (plug_wr_i),
      .plug_a_i  (plug_a_i),
      .plug_b_i  (plug_b_i),
      .plug_clr_i(plug_clr_i),
`endif
      .sym_o     (sym_o),
      .pos_o     (pos_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      int sym;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   ml, mm, mr;
   int   pm [26];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int wiring(input int r, input int k);
      string s;
      case (r)
         0:       s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
         1:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
         2:       s = "BDFHJLCPRTXNYEQGVIUAZMWSKO";
         default: s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
      endcase
      return int'(s[k]) - 65;
   endfunction

   function automatic int rot(input int r, input int c, input int p, input bit inv);
      int x;
      int y;
      x = (c + p) % 26;
      y = 0;
      if (!inv) y = wiring(r, x);
      else for (int i = 0; i < 26; i++) if (wiring(r, i) == x) y = i;
      return (y - p + 26) % 26;
   endfunction

   // Letter path through plugboard, rotors III/II/I, reflector, and back
   function automatic int ref_cipher(input int c);
      int x;
      x = pm[c];
      x = rot(2, x, mr, 0);
      x = rot(1, x, mm, 0);
      x = rot(0, x, ml, 0);
      x = wiring(3, x);
      x = rot(0, x, ml, 1);
      x = rot(1, x, mm, 1);
      x = rot(2, x, mr, 1);
      return pm[x];
   endfunction

   function automatic logic [14:0] model_pos();
      return {5'(ml), 5'(mm), 5'(mr)};
   endfunction

   task automatic model_reset();
      ml = int'(POS_RST[14:10]);
      mm = int'(POS_RST[9:5]);
      mr = int'(POS_RST[4:0]);
   endtask

   // One cycle of stimulus; fexp >= 0 overrides the model's expected ciphertext
   task automatic drive(input logic [6:0] s, input logic ld, input logic [14:0] cp, input int fexp);
      bit adv_m;
      bit adv_l;
      exp_t e;
      @(negedge clk_i);
      chk("pos_o", int'(pos_o), int'(model_pos()));
      sym_i     = s;
      cfg_ld_i  = ld;
      cfg_pos_i = cp;
      if (ld) begin
         ml = int'(cp[14:10]) % 26;
         mm = int'(cp[9:5]) % 26;
         mr = int'(cp[4:0]) % 26;
      end else if (int'(s) >= 1 && int'(s) <= 26) begin
         adv_m = (mr == 21) || (mm == 4);
         adv_l = (mm == 4);
         mr = (mr + 1) % 26;
         if (adv_m) mm = (mm + 1) % 26;
         if (adv_l) ml = (ml + 1) % 26;
         e.sym = (fexp >= 0) ? fexp : ref_cipher(int'(s) - 1) + 1;
         e.due = cyc + 2;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      drive(7'd0, 1'b0, 15'd0, -1);
   endtask

   // Waits for the edge that samples the current inputs, then checks positions
   task automatic chk_pos_const(input string name, input logic [14:0] want);
      @(posedge clk_i);
      #1;
      chk(name, int'(pos_o), int'(want));
   endtask

   task automatic pulse_rst();
      @(negedge clk_i);
      sym_i    = '0;
      cfg_ld_i = 1'b0;
      rst_i    = 1'b1;
      #1;
      chk("rst_sym_o", int'(sym_o), 0);
      chk("rst_pos_o", int'(pos_o), int'(POS_RST));
      exp_q.delete();
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Monitor: every non-zero output must match the oldest expectation at its due cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         cyc++;
         #1;
         if (!rst_i && sym_o != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_sym_o", int'(sym_o), 0);
            end else begin
               e = exp_q.pop_front();
               chk("sym_o", int'(sym_o), e.sym);
               chk("sym_o_latency", cyc, e.due);
            end
         end
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_sym_o", 0, e.sym);
         end
      end
   end

   initial begin
      logic [14:0] rcp;
      int          r;
      for (int i = 0; i < 26; i++) pm[i] = i;
      model_reset();
      rst_i     = 1'b1;
      sym_i     = '0;
      cfg_ld_i  = 1'b0;
      cfg_pos_i = '0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_wr_i  = 1'b0;
      plug_a_i   = '0;
      plug_b_i   = '0;
      plug_clr_i = 1'b0;
`endif
      repeat (3) @(negedge clk_i);
      chk("reset_sym_o", int'(sym_o), 0);
      chk("reset_pos_o", int'(pos_o), int'(POS_RST));
      rst_i = 1'b0;

      // AAAAA at AAA enciphers to BDZGO
      drive(7'd1, 1'b0, 15'd0, 2);
      drive(7'd1, 1'b0, 15'd0, 4);
      drive(7'd1, 1'b0, 15'd0, 26);
      drive(7'd1, 1'b0, 15'd0, 7);
      drive(7'd1, 1'b0, 15'd0, 15);
      chk_pos_const("pos_after_5", {5'd0, 5'd0, 5'd5});

      // Double step ADU -> ADV -> AEW -> BFX
      drive(7'd0, 1'b1, {5'd0, 5'd3, 5'd20}, -1);
      chk_pos_const("pos_load_adu", {5'd0, 5'd3, 5'd20});
      drive(7'd9, 1'b0, 15'd0, -1);
      chk_pos_const("pos_adv", {5'd0, 5'd3, 5'd21});
      drive(7'd3, 1'b0, 15'd0, -1);
      chk_pos_const("pos_aew", {5'd0, 5'd4, 5'd22});
      drive(7'd20, 1'b0, 15'd0, -1);
      chk_pos_const("pos_bfx", {5'd1, 5'd5, 5'd23});

      // Idle and out-of-range codes neither step nor emit
      drive(7'd0, 1'b0, 15'd0, -1);
      drive(7'd27, 1'b0, 15'd0, -1);
      drive(7'h7F, 1'b0, 15'd0, -1);
      chk_pos_const("pos_invalid_hold", {5'd1, 5'd5, 5'd23});

      // Reciprocity: BDZGO at AAA deciphers to AAAAA
      drive(7'd0, 1'b1, 15'd0, -1);
      drive(7'd2, 1'b0, 15'd0, 1);
      drive(7'd4, 1'b0, 15'd0, 1);
      drive(7'd26, 1'b0, 15'd0, 1);
      drive(7'd7, 1'b0, 15'd0, 1);
      drive(7'd15, 1'b0, 15'd0, 1);

      // Load beats a same-cycle symbol; out-of-range load values wrap mod 26
      drive(7'd5, 1'b1, {5'd2, 5'd7, 5'd11}, -1);
      chk_pos_const("pos_load_priority", {5'd2, 5'd7, 5'd11});
      drive(7'd0, 1'b1, {5'd31, 5'd26, 5'd25}, -1);
      chk_pos_const("pos_load_mod26", {5'd5, 5'd0, 5'd25});

      // Reset with two symbols in flight
      drive(7'd8, 1'b0, 15'd0, -1);
      drive(7'd12, 1'b0, 15'd0, -1);
      pulse_rst();

`ifdef ENIGMA_PLUGBOARD_EN
      repeat (3) idle();
      @(negedge clk_i);
      plug_wr_i = 1'b1; plug_a_i = 5'd0; plug_b_i = 5'd1;
      pm[0] = 1; pm[1] = 0;
      @(negedge clk_i);
      plug_wr_i = 1'b1; plug_a_i = 5'd3; plug_b_i = 5'd3;
      @(negedge clk_i);
      plug_wr_i = 1'b1; plug_a_i = 5'd2; plug_b_i = 5'd28;
      @(negedge clk_i);
      plug_wr_i = 1'b0;
      drive(7'd0, 1'b1, 15'd0, -1);
      drive(7'd2, 1'b0, 15'd0, -1);
      drive(7'd1, 1'b0, 15'd0, -1);
      drive(7'd3, 1'b0, 15'd0, -1);
      repeat (3) idle();
      @(negedge clk_i);
      plug_wr_i = 1'b1; plug_a_i = 5'd1; plug_b_i = 5'd4;
      pm[0] = 0; pm[1] = 4; pm[4] = 1;
      @(negedge clk_i);
      plug_wr_i = 1'b0;
      drive(7'd5, 1'b0, 15'd0, -1);
      drive(7'd1, 1'b0, 15'd0, -1);
      repeat (3) idle();
      @(negedge clk_i);
      plug_clr_i = 1'b1; plug_wr_i = 1'b1; plug_a_i = 5'd7; plug_b_i = 5'd9;
      for (int i = 0; i < 26; i++) pm[i] = i;
      @(negedge clk_i);
      plug_clr_i = 1'b0; plug_wr_i = 1'b0;
      drive(7'd0, 1'b1, 15'd0, -1);
      drive(7'd1, 1'b0, 15'd0, 2);
`endif

      // Randomized traffic: symbols, junk codes, loads, load+symbol collisions, rare resets
      for (int n = 0; n < 400; n++) begin
         r   = int'($urandom_range(0, 99));
         rcp = 15'($urandom);
         if (r < 72)      drive(7'($urandom_range(1, 26)), 1'b0, 15'd0, -1);
         else if (r < 80) drive(7'd0, 1'b0, 15'd0, -1);
         else if (r < 88) drive(7'($urandom_range(27, 127)), 1'b0, 15'd0, -1);
         else if (r < 94) drive(7'd0, 1'b1, rcp, -1);
         else if (r < 98) drive(7'($urandom_range(1, 26)), 1'b1, rcp, -1);
         else             pulse_rst();
      end

      repeat (4) idle();
      @(negedge clk_i);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
